pipelined_multiplier: RTL and testbench

Parametrised integer multiply functional unit for the execute stage; successor to the single-register multiplier.
- Width (XLEN) and pipeline depth (NUM_STAGES) are parametrised.
- Adds output backpressure (whole-pipe stall) and a flush that kills in-flight operations.
- Supports MUL, MULH, MULHU, MULHSU and MULW; results return tagged with trans_id for writeback.

---
 rtl/pipelined_multiplier_pkg.sv | 46 ++++
 rtl/pipelined_multiplier_stage.sv | 44 ++++
 rtl/pipelined_multiplier.sv | 113 +++++++++++
 tb/tb_pipelined_multiplier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_multiplier_pkg
// Shared types and helpers for the pipelined integer multiplier.
//   fu_op           : functional-unit operator encoding (multiply ops and a
//                     few non-multiply ops that the unit must reject)
//   mult_payload_t  : per-stage payload (tag, operator, full product). Sized
//                     for the widest configuration; narrower builds use the
//                     low bits only.
//   is_mult_op      : operator membership test for the multiply unit
//   sext32          : sign-extend a 32-bit value to 64 bits
// Optional feature macro used by the top: MULT_PERF_CNT_EN
// ---------------------------------------------------------------------------
package pipelined_multiplier_pkg;

    localparam int TRANS_ID_BITS = 3;
    localparam int XLEN_MAX      = 64;
    localparam int TID_MAX       = 8;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        MUL    = 4'd2,
        MULH   = 4'd3,
        MULHU  = 4'd4,
        MULHSU = 4'd5,
        MULW   = 4'd6,
        DIV    = 4'd7
    } fu_op;

    typedef struct packed {
        logic [TID_MAX-1:0]    trans_id;
        fu_op                  op;
        logic [2*XLEN_MAX-1:0] product;
    } mult_payload_t;

    localparam mult_payload_t MULT_PAYLOAD_RST = '{trans_id: '0, op: MUL, product: '0};

    function automatic logic is_mult_op(input fu_op op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/pipelined_multiplier_stage.sv
// ---------------------------------------------------------------------------
// mult_pipe_stage
// One register slot of the multiplier pipe: a valid bit plus payload.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : advance enable (low while the pipe is stalled)
//   i_clr          : kill the slot's valid bit; wins over i_en
//   i_valid/i_data : slot input
//   o_valid/o_data : slot contents
// ---------------------------------------------------------------------------
module mult_pipe_stage
    import pipelined_multiplier_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_valid,
    input  mult_payload_t i_data,
    output logic          o_valid,
    output mult_payload_t o_data
);

    logic          r_valid;
    mult_payload_t r_data;

    // Clear only touches the valid bit; payload is don't-care once invalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= MULT_PAYLOAD_RST;
        end else begin
            if (i_clr)
                r_valid <= 1'b0;
            else if (i_en)
                r_valid <= i_valid;
            if (i_en)
                r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipelined_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_multiplier
// Integer multiply unit (MUL/MULH/MULHU/MULHSU/MULW) with NUM_STAGES cycles
// of latency, whole-pipe stall on output backpressure and a flush.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : kill every in-flight op (incl. one accepted now)
//   in_valid_i/in_ready_o  : input handshake
//   operator_i             : operator; non-multiply ops are dropped
//   operand_a_i/operand_b_i: rs1 / rs2
//   trans_id_i/trans_id_o  : writeback tag
//   result_o               : selected product
//   out_valid_o/out_ready_i: output handshake
//   mult_count_o           : completed output handshakes (only with
//                            MULT_PERF_CNT_EN defined)
// ---------------------------------------------------------------------------
module pipelined_multiplier
    import pipelined_multiplier_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int NUM_STAGES    = 2,
    parameter int TRANS_ID_BITS = pipelined_multiplier_pkg::TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  fu_op                     operator_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [63:0]              mult_count_o
`endif
);

    logic            w_stall;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic            w_vld [NUM_STAGES+1];
    mult_payload_t   w_pl  [NUM_STAGES+1];
    mult_payload_t   w_last;
    logic [63:0]     w_sext;

    assign w_stall    = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~w_stall;

    // The (XLEN+1)-bit signed product truncated to 2*XLEN bits equals the
    // low 2*XLEN bits of a product of operands extended straight to 2*XLEN.
    assign w_sign_a = (operator_i == MULH) | (operator_i == MULHSU);
    assign w_sign_b = (operator_i == MULH);
    assign w_a_ext  = {{XLEN{w_sign_a & operand_a_i[XLEN-1]}}, operand_a_i};
    assign w_b_ext  = {{XLEN{w_sign_b & operand_b_i[XLEN-1]}}, operand_b_i};
    assign w_prod   = w_a_ext * w_b_ext;

    // Stage-0 input: product is formed here and retimed into the pipe.
    always_comb begin
        w_pl[0]                              = MULT_PAYLOAD_RST;
        w_pl[0].trans_id[TRANS_ID_BITS-1:0]  = trans_id_i;
        w_pl[0].op                           = operator_i;
        w_pl[0].product[2*XLEN-1:0]          = w_prod;
    end
    // Stall already blocks loading, so no in_ready qualification needed.
    assign w_vld[0] = in_valid_i & is_mult_op(operator_i);

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        mult_pipe_stage u_stage (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_en    (~w_stall),
            .i_clr   (flush_i),
            .i_valid (w_vld[s]),
            .i_data  (w_pl[s]),
            .o_valid (w_vld[s+1]),
            .o_data  (w_pl[s+1])
        );
    end

    assign w_last      = w_pl[NUM_STAGES];
    assign out_valid_o = w_vld[NUM_STAGES];
    assign trans_id_o  = w_last.trans_id[TRANS_ID_BITS-1:0];
    assign w_sext      = sext32(w_last.product[31:0]);

    always_comb begin
        case (w_last.op)
            MULH, MULHU, MULHSU: result_o = w_last.product[2*XLEN-1:XLEN];
            MULW:                result_o = w_sext[XLEN-1:0];
            default:             result_o = w_last.product[XLEN-1:0];
        endcase
    end

`ifdef MULT_PERF_CNT_EN
    logic [63:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_count <= '0;
        else if (out_valid_o & out_ready_i)
            r_count <= r_count + 64'd1;
    end

    assign mult_count_o = r_count;
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;
    import pipelined_multiplier_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    // 32-bit unit (main)
    logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1;
    fu_op        a_op = MUL;
    logic [31:0] a_x = '0, a_y = '0, a_res;
    logic [2:0]  a_tid = '0, a_tido;
    // 64-bit unit (MULW)
    logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1;
    fu_op        b_op = MUL;
    logic [63:0] b_x = '0, b_y = '0, b_res;
    logic [2:0]  b_tid = '0, b_tido;
`ifdef MULT_PERF_CNT_EN
    logic [63:0] a_cnt, b_cnt;
`endif

    pipelined_multiplier #(.XLEN(32), .NUM_STAGES(2), .TRANS_ID_BITS(3)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .operator_i(a_op),
        .operand_a_i(a_x), .operand_b_i(a_y), .trans_id_i(a_tid),
        .result_o(a_res), .out_valid_o(a_ov), .out_ready_i(a_or), .trans_id_o(a_tido)
`ifdef MULT_PERF_CNT_EN
        , .mult_count_o(a_cnt)
`endif
    );

    pipelined_multiplier #(.XLEN(64), .NUM_STAGES(2), .TRANS_ID_BITS(3)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .operator_i(b_op),
        .operand_a_i(b_x), .operand_b_i(b_y), .trans_id_i(b_tid),
        .result_o(b_res), .out_valid_o(b_ov), .out_ready_i(b_or), .trans_id_o(b_tido)
`ifdef MULT_PERF_CNT_EN
        , .mult_count_o(b_cnt)
`endif
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input fu_op op, input logic [31:0] x, input logic [31:0] y, input logic [2:0] id);
        a_iv = 1'b1; a_op = op; a_x = x; a_y = y; a_tid = id;
    endtask

    task automatic idle();
        a_iv = 1'b0;
    endtask

    logic [2:0]  tids [4] = '{3'd5, 3'd6, 3'd7, 3'd0};
    logic [31:0] exps [4] = '{32'd10, 32'd20, 32'd30, 32'd40};

    initial begin
        int k, got, stall_left;
        bit started;
        logic [31:0] hold_r;
        logic [2:0]  hold_t;

        // reset state
        #2;
        chk("rst_ov", a_ov, 0);
        chk("rst_res", a_res, 0);
        chk("rst_tid", a_tido, 0);
        chk("rst_ir", a_ir, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // MUL 7*6, two-cycle latency
        drv(MUL, 32'd7, 32'd6, 3'd3);
        tick(); idle();
        chk("mul_lat1_ov", a_ov, 0);
        tick();
        chk("mul_ov", a_ov, 1);
        chk("mul_res", a_res, 32'h0000002A);
        chk("mul_tid", a_tido, 3);
        tick();
        chk("mul_after_ov", a_ov, 0);

        // high-half ops back to back with a=b=0xFFFFFFFF
        drv(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1);
        tick();
        drv(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2);
        tick();
        chk("mulh_ov", a_ov, 1);
        chk("mulh_res", a_res, 32'h00000000);
        chk("mulh_tid", a_tido, 1);
        drv(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4);
        tick(); idle();
        chk("mulhu_ov", a_ov, 1);
        chk("mulhu_res", a_res, 32'hFFFFFFFE);
        chk("mulhu_tid", a_tido, 2);
        tick();
        chk("mulhsu_ov", a_ov, 1);
        chk("mulhsu_res", a_res, 32'hFFFFFFFF);
        chk("mulhsu_tid", a_tido, 4);
        tick();
        chk("hi_after_ov", a_ov, 0);

        // MULW on the 64-bit unit
        b_iv = 1'b1; b_op = MULW; b_x = 64'h7FFFFFFF; b_y = 64'd2; b_tid = 3'd5;
        tick(); b_iv = 1'b0;
        tick();
        chk("mulw_ov", b_ov, 1);
        chk("mulw_res", b_res, 64'hFFFFFFFFFFFFFFFE);
        chk("mulw_tid", b_tido, 5);
        tick();

        // backpressure: four ops streamed, 3-cycle stall at first result
        k = 0; got = 0; stall_left = 0; started = 0; hold_r = '0; hold_t = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (a_ov && !started) begin
                started = 1; stall_left = 3; hold_r = a_res; hold_t = a_tido;
            end
            a_or = (stall_left > 0) ? 1'b0 : 1'b1;
            if (k < 4) drv(MUL, 32'(k + 1), 32'd10, tids[k]);
            else idle();
            #1;
            if (stall_left > 0) begin
                chk("bp_inrdy", a_ir, 0);
                chk("bp_hold_res", a_res, hold_r);
                chk("bp_hold_tid", a_tido, hold_t);
                stall_left--;
            end else if (a_ov) begin
                if (got < 4) begin
                    chk("bp_res", a_res, exps[got]);
                    chk("bp_tid", a_tido, tids[got]);
                end
                got++;
            end
            if (a_iv && a_ir) k++;
            tick();
        end
        a_or = 1'b1; idle();
        chk("bp_stalled", started, 1);
        chk("bp_delivered", got, 4);
        chk("bp_issued", k, 4);
        chk("bp_end_ov", a_ov, 0);

        // flush while stalled, with a third op offered on the flush edge
        drv(MUL, 32'd3, 32'd3, 3'd1);
        tick();
        drv(MUL, 32'd4, 32'd4, 3'd2);
        tick();
        drv(MUL, 32'd2, 32'd2, 3'd3);
        a_or = 1'b0; flush = 1'b1;
        #1;
        chk("fl_stall_ir", a_ir, 0);
        tick();
        flush = 1'b0; a_or = 1'b1; idle();
        chk("fl_ir", a_ir, 1);
        for (int i = 0; i < 3; i++) begin
            chk("fl_no_ov", a_ov, 0);
            tick();
        end
        drv(MUL, 32'd5, 32'd5, 3'd6);
        tick(); idle();
        tick();
        chk("fl_next_ov", a_ov, 1);
        chk("fl_next_res", a_res, 32'd25);
        chk("fl_next_tid", a_tido, 6);
        tick();

        // non-multiply operator is dropped
        drv(ADD, 32'd1, 32'd2, 3'd7);
        tick(); idle();
        tick();
        chk("add_ov", a_ov, 0);
        tick();
        chk("add_ov2", a_ov, 0);

`ifdef MULT_PERF_CNT_EN
        chk("cnt32", a_cnt, 64'd9);
        chk("cnt64", b_cnt, 64'd1);
`endif

        // asynchronous reset mid-operation
        drv(MUL, 32'd9, 32'd9, 3'd2);
        tick(); idle();
        tick();
        chk("ar_pre_ov", a_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov", a_ov, 0);
        chk("ar_ir", a_ir, 1);
`ifdef MULT_PERF_CNT_EN
        chk("ar_cnt", a_cnt, 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("ar_post_ov", a_ov, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
